// File: rtl/usb_time_report_pkg.sv
// Shared types for the DCF77 time-report IN endpoint.
// USB_REPORT_DATE_EN selects the long report (time plus date, 8 bytes).
// Without it, the report carries only status and time (4 bytes).
package usb_time_report_pkg;

    // One BCD digit; clock fields are bcd_t [1:0] = {tens, ones}
    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND
    } usb_report_state_e;

`ifdef USB_REPORT_DATE_EN
    localparam int USB_REPORT_LEN = 8;
`else
    localparam int USB_REPORT_LEN = 4;
`endif

    // Snapshot of everything the report carries; frozen for the life of a packet
    typedef struct packed {
        logic       sync;
        logic       error;
        bcd_t [1:0] hour;
        bcd_t [1:0] minute;
        bcd_t [1:0] second;
`ifdef USB_REPORT_DATE_EN
        bcd_t [1:0] year;
        bcd_t [1:0] month;
        bcd_t [1:0] day;
        logic [2:0] day_of_week;
`endif
    } usb_report_t;

endpackage

// File: rtl/usb_time_report_if.sv
// SIE <-> endpoint handshake for one IN endpoint slot.
// master: the endpoint (drives report bytes); slave: the SIE.
interface usb_time_report_if;

    logic       in_token;
    logic       in_ack;
    logic [7:0] endpi_data;
    logic       endpi_valid;
    logic       endpi_crc16;
    logic       endpi_ready;

    modport master (
        input  in_token, in_ack, endpi_ready,
        output endpi_data, endpi_valid, endpi_crc16
    );

    modport slave (
        output in_token, in_ack, endpi_ready,
        input  endpi_data, endpi_valid, endpi_crc16
    );

endinterface

// File: rtl/usb_time_report.sv
// IN-endpoint controller: snapshots the DCF77 clock on an IN token and
// streams a fixed-length report to the SIE, retransmitting the same
// snapshot until the host ACKs it.
// USB_REPORT_DATE_EN: when defined, the report includes the date (8 bytes).
module usb_time_report
    import usb_time_report_pkg::*;
#(
    parameter int ENDP_NUM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usb_reset,
    usb_time_report_if.master ep,
    input  bcd_t [1:0]        year,
    input  bcd_t [1:0]        month,
    input  bcd_t [1:0]        day,
    input  bcd_t [1:0]        hour,
    input  bcd_t [1:0]        minute,
    input  bcd_t [1:0]        second,
    input  logic [2:0]        day_of_week,
    input  logic              dcf77_sync,
    input  logic              dcf77_error
);

    localparam logic [2:0] LAST_IDX = 3'(USB_REPORT_LEN - 1);

    usb_report_state_e state_reg;
    usb_report_t       snap_reg;
    usb_report_t       live;
    logic [2:0]        idx_reg;
    logic [3:0]        seq_reg;
    logic              pending_reg;
    logic              ack_flag_reg;
    logic [7:0]        data_reg;
    logic              valid_reg;
    logic              crc16_reg;

    // ENDP_NUM is informational only; date inputs are dead in the short report
`ifdef USB_REPORT_DATE_EN
    logic unused_cfg;
    assign unused_cfg = ^{32'(ENDP_NUM)};
`else
    logic unused_cfg;
    assign unused_cfg = ^{year, month, day, day_of_week, 32'(ENDP_NUM)};
`endif

    // Current clock and receiver status, in snapshot layout
    always_comb begin
        live        = '0;
        live.sync   = dcf77_sync;
        live.error  = dcf77_error;
        live.hour   = hour;
        live.minute = minute;
        live.second = second;
`ifdef USB_REPORT_DATE_EN
        live.year        = year;
        live.month       = month;
        live.day         = day;
        live.day_of_week = day_of_week;
`endif
    end

    // Report byte at position i; seq is stable while a snapshot is pending
    function automatic logic [7:0] report_byte(input usb_report_t r,
                                               input logic [3:0] s,
                                               input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            3'd0: b = {r.sync, r.error, 2'b00, s};
            3'd1: b = r.hour;
            3'd2: b = r.minute;
            3'd3: b = r.second;
`ifdef USB_REPORT_DATE_EN
            3'd4: b = r.year;
            3'd5: b = r.month;
            3'd6: b = r.day;
            3'd7: b = {5'b00000, r.day_of_week};
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Endpoint FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            snap_reg     <= '0;
            idx_reg      <= '0;
            seq_reg      <= '0;
            pending_reg  <= 1'b0;
            ack_flag_reg <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            crc16_reg    <= 1'b0;
        end else if (usb_reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            seq_reg      <= '0;
            pending_reg  <= 1'b0;
            ack_flag_reg <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            crc16_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    crc16_reg <= 1'b0;
                    // An ack (fresh or held from the last packet) retires the snapshot
                    // before any same-cycle token reaches SNAP.
                    if ((ep.in_ack || ack_flag_reg) && pending_reg) begin
                        pending_reg <= 1'b0;
                        seq_reg     <= seq_reg + 4'd1;
                    end
                    ack_flag_reg <= 1'b0;
                    if (ep.in_token) begin
                        state_reg <= SNAP;
                    end
                end
                SNAP: begin
                    if (ep.in_ack) begin
                        ack_flag_reg <= 1'b1;
                    end
                    if (!pending_reg) begin
                        snap_reg    <= live;
                        pending_reg <= 1'b1;
                    end
                    idx_reg   <= '0;
                    state_reg <= SEND;
                end
                SEND: begin
                    if (ep.in_ack) begin
                        ack_flag_reg <= 1'b1;
                    end
                    if (!valid_reg) begin
                        // First beat: snapshot settled during SNAP, load byte 0
                        valid_reg <= 1'b1;
                        data_reg  <= report_byte(snap_reg, seq_reg, idx_reg);
                        crc16_reg <= (idx_reg == LAST_IDX);
                    end else if (ep.endpi_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            valid_reg <= 1'b0;
                            crc16_reg <= 1'b0;
                            data_reg  <= '0;
                            idx_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 3'd1;
                            data_reg  <= report_byte(snap_reg, seq_reg, idx_reg + 3'd1);
                            crc16_reg <= ((idx_reg + 3'd1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ep.endpi_data  = data_reg;
    assign ep.endpi_valid = valid_reg;
    assign ep.endpi_crc16 = crc16_reg;

endmodule

// File: tb/tb_usb_time_report.sv
// Directed bench for usb_time_report: reset, basic packet, backpressure,
// retransmission, seq wrap, ack/token collision and usb_reset mid-packet.
module tb_usb_time_report;
    import usb_time_report_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       usb_reset = 1'b0;
    logic [7:0] year = 8'h00, month = 8'h00, day = 8'h00;
    logic [7:0] hour = 8'h00, minute = 8'h00, second = 8'h00;
    logic [2:0] day_of_week = 3'd0;
    logic       dcf77_sync = 1'b0, dcf77_error = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_pkt [8];
    int         pat [4] = '{1, 0, 0, 1};

    usb_time_report_if ep();

    usb_time_report #(.ENDP_NUM(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .usb_reset   (usb_reset),
        .ep          (ep),
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .day_of_week (day_of_week),
        .dcf77_sync  (dcf77_sync),
        .dcf77_error (dcf77_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected report: status byte and seconds vary, the rest is the fixed test clock
    task automatic set_exp(input logic [7:0] st, input logic [7:0] sec);
        exp_pkt[0] = st;
        exp_pkt[1] = 8'h23;
        exp_pkt[2] = 8'h59;
        exp_pkt[3] = sec;
        exp_pkt[4] = 8'h24;
        exp_pkt[5] = 8'h12;
        exp_pkt[6] = 8'h31;
        exp_pkt[7] = 8'h02;
    endtask

    // Drive token/ack high across exactly one rising edge
    task automatic pulse(input logic tok, input logic ack);
        @(negedge clk);
        ep.in_token = tok;
        ep.in_ack   = ack;
        @(negedge clk);
        ep.in_token = 1'b0;
        ep.in_ack   = 1'b0;
    endtask

    // Called right after pulse(): receive one packet, mode 0 = ready always, 1 = 1,0,0,1
    task automatic collect(input string tag, input int mode);
        int         n = 0;
        int         cyc = 0;
        int         vcyc = 0;
        logic       r;
        logic       pv = 1'b0;
        logic       pr = 1'b1;
        logic       pc = 1'b0;
        logic [7:0] pd = 8'h00;
        ep.endpi_ready = 1'b0;
        chk({tag, "/lat1"}, 32'(ep.endpi_valid), 32'd0);
        @(negedge clk);
        chk({tag, "/lat2"}, 32'(ep.endpi_valid), 32'd0);
        while (n < USB_REPORT_LEN && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk({tag, "/lat3"}, 32'(ep.endpi_valid), 32'd1);
            end
            if (pv && !pr) begin
                chk($sformatf("%s/hold_d%0d", tag, n), 32'(ep.endpi_data), 32'(pd));
                chk($sformatf("%s/hold_v%0d", tag, n), 32'(ep.endpi_valid), 32'd1);
                chk($sformatf("%s/hold_c%0d", tag, n), 32'(ep.endpi_crc16), 32'(pc));
            end
            r = (mode == 0) ? 1'b1 : (pat[(cyc - 1) % 4] != 0);
            ep.endpi_ready = r;
            if (ep.endpi_valid) begin
                vcyc++;
                if (r) begin
                    chk($sformatf("%s/byte%0d", tag, n), 32'(ep.endpi_data), 32'(exp_pkt[n]));
                    chk($sformatf("%s/crc%0d", tag, n), 32'(ep.endpi_crc16),
                        32'(n == USB_REPORT_LEN - 1));
                    n++;
                end
            end
            pv = ep.endpi_valid;
            pr = r;
            pd = ep.endpi_data;
            pc = ep.endpi_crc16;
        end
        chk({tag, "/beats"}, 32'(n), 32'(USB_REPORT_LEN));
        @(negedge clk);
        ep.endpi_ready = 1'b0;
        chk({tag, "/vdrop"}, 32'(ep.endpi_valid), 32'd0);
        if (mode == 0) begin
            chk({tag, "/vcycles"}, 32'(vcyc), 32'(USB_REPORT_LEN));
        end
        $display("packet %s: %0d beats in %0d cycles", tag, n, cyc);
    endtask

    initial begin
        ep.in_token    = 1'b0;
        ep.in_ack      = 1'b0;
        ep.endpi_ready = 1'b0;

        // 1: reset state, then async reset in the middle of SEND
        repeat (3) @(negedge clk);
        chk("rst/valid", 32'(ep.endpi_valid), 32'd0);
        chk("rst/data", 32'(ep.endpi_data), 32'd0);
        chk("rst/crc", 32'(ep.endpi_crc16), 32'd0);
        rst = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst/insend", 32'(ep.endpi_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst/async_valid", 32'(ep.endpi_valid), 32'd0);
        chk("rst/async_data", 32'(ep.endpi_data), 32'd0);
        chk("rst/async_crc", 32'(ep.endpi_crc16), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 2: basic packet, 23:59:58 2024-12-31 Tue, locked
        hour = 8'h23; minute = 8'h59; second = 8'h58;
        year = 8'h24; month = 8'h12; day = 8'h31;
        day_of_week = 3'd2; dcf77_sync = 1'b1; dcf77_error = 1'b0;
        set_exp(8'h80, 8'h58);
        pulse(1'b1, 1'b0);
        collect("basic", 0);

        // 3: backpressure on a retransmission of the same snapshot
        pulse(1'b1, 1'b0);
        collect("bp", 1);

        // 4: clock moves on, no ack -> identical packet; after ack -> fresh, seq 1
        second = 8'h59;
        pulse(1'b1, 1'b0);
        collect("retx", 0);
        pulse(1'b0, 1'b1);
        set_exp(8'h81, 8'h59);
        pulse(1'b1, 1'b0);
        collect("acked", 0);

        // 5: seq runs 2..15 then wraps to 0
        for (int k = 1; k <= 15; k++) begin
            pulse(1'b0, 1'b1);
            set_exp(8'h80 | 8'((1 + k) % 16), 8'h59);
            pulse(1'b1, 1'b0);
            collect($sformatf("wrap%0d", k), 0);
        end

        // 5: ack and token together -> ack first, fresh snapshot, seq 1
        second = 8'h00; dcf77_error = 1'b1;
        set_exp(8'hC1, 8'h00);
        pulse(1'b1, 1'b1);
        collect("simul", 0);

        // 6: usb_reset while byte 3 is on the bus
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("ureset/b0", 32'(ep.endpi_data), 32'hC1);
        ep.endpi_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("ureset/b3", 32'(ep.endpi_data), 32'h00);
        chk("ureset/b3crc", 32'(ep.endpi_crc16), 32'(USB_REPORT_LEN == 4));
        ep.endpi_ready = 1'b0;
        usb_reset = 1'b1;
        @(negedge clk);
        chk("ureset/valid", 32'(ep.endpi_valid), 32'd0);
        chk("ureset/crc", 32'(ep.endpi_crc16), 32'd0);
        usb_reset = 1'b0;
        $display("usb_reset applied at idx 3");
        second = 8'h30; dcf77_error = 1'b0;
        set_exp(8'h80, 8'h30);
        pulse(1'b1, 1'b0);
        collect("post_ureset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
